serial_compmag: RTL and testbench

Sequential, parametrised magnitude comparator. It compares two WIDTH-bit operands DIGIT bits per cycle, most significant digit first, and stops at the first unequal digit. Operands can be compared as unsigned or two's-complement. The block extends the team's combinational 4-bit eq/gt/lt comparator to wide operands where a single-cycle compare chain would not meet timing, and sits behind a start/done handshake on the datapath control bus.

---
 rtl/serial_compmag.sv | 144 ++++++++++++++
 tb/tb_serial_compmag.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_compmag.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands DIGIT bits
// per cycle, most significant digit first, stopping at the first unequal digit.
// Signed compares flip the operand sign bits at capture so that the digit
// compare can always be unsigned.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results and ndig hold the last compare
// RUN   | comparing the top digit of sa/sb, one digit per cycle
// DONE  | results just updated; done pulses, back to IDLE next cycle
module serial_compmag #(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 4,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb,
  output logic [CW-1:0]    ndig
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aeqb_q, aeqb_d;
  logic             agtb_q, agtb_d;
  logic             altb_q, altb_d;
  logic [CW-1:0]    ndig_q, ndig_d;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;

  assign dig_a = sa_q[WIDTH-1 -: DIGIT];
  assign dig_b = sb_q[WIDTH-1 -: DIGIT];

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;
    ndig_d  = ndig_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = signed_mode ? (a ^ MSB_MASK) : a;
          sb_d    = signed_mode ? (b ^ MSB_MASK) : b;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (dig_a != dig_b) begin
          aeqb_d  = 1'b0;
          agtb_d  = (dig_a > dig_b);
          altb_d  = (dig_a < dig_b);
          ndig_d  = cnt_q + CW'(1);
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          aeqb_d  = 1'b1;
          agtb_d  = 1'b0;
          altb_d  = 1'b0;
          ndig_d  = cnt_q + CW'(1);
          state_d = DONE;
        end else begin
          sa_d = sa_q << DIGIT;
          sb_d = sb_q << DIGIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy/done are registered from the next state so outputs stay flop-driven.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, shift registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
      ndig_q  <= ndig_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign aeqb = aeqb_q;
  assign agtb = agtb_q;
  assign altb = altb_q;
  assign ndig = ndig_q;

endmodule

// File: tb/tb_serial_compmag.sv
// Self-checking bench for serial_compmag: default 16/4 instance plus 8/1 and
// 8/8 instances, checked against an arithmetic reference model.
module tb_serial_compmag;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, aeqb, agtb, altb;
  logic [2:0]  ndig;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        sm8 = 1'b0, st1 = 1'b0, st8 = 1'b0;
  logic        busy1, done1, eq1, gt1, lt1;
  logic [3:0]  nd1;
  logic        busy8, done8, eq8, gt8, lt8;
  logic [0:0]  nd8;

  int checks = 0;
  int failures = 0;

  logic       exp_eq = 1'b0, exp_gt = 1'b0, exp_lt = 1'b0;
  logic [2:0] exp_nd = '0;

  always #5 clk = ~clk;

  serial_compmag #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .aeqb(aeqb), .agtb(agtb),
    .altb(altb), .ndig(ndig));

  serial_compmag #(.WIDTH(8), .DIGIT(1)) dut_w8d1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy1), .done(done1), .aeqb(eq1), .agtb(gt1),
    .altb(lt1), .ndig(nd1));

  serial_compmag #(.WIDTH(8), .DIGIT(8)) dut_w8d8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .aeqb(eq8), .agtb(gt8),
    .altb(lt8), .ndig(nd8));

  // 1-based index of the first unequal digit from the MSB, or NDIG if equal.
  function automatic int first_diff(input int unsigned x, input int unsigned y,
                                    input int w, input int d);
    for (int i = 1; i <= w / d; i++) begin
      if (((x >> (w - i * d)) % (1 << d)) != ((y >> (w - i * d)) % (1 << d)))
        return i;
    end
    return w / d;
  endfunction

  function automatic int value_of(input int unsigned x, input int w, input logic sgn);
    if (sgn && x >= (1 << (w - 1))) return int'(x) - (1 << w);
    return int'(x);
  endfunction

  // One compare on the 16/4 instance; checks busy/done/results every cycle.
  task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic sm,
                       input bit scramble, output int dcyc);
    int m, va, vb;
    m  = first_diff(ia, ib, 16, 4);
    va = value_of(ia, 16, sm);
    vb = value_of(ib, 16, sm);
    dcyc = -1;
    @(negedge clk);
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL busy_cycle0 got=%b exp=0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= m + 2; k++) begin
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
      end
      @(negedge clk);
      if (done === 1'b1 && dcyc < 0) dcyc = k;
      if (k == m + 1) begin
        exp_eq = (va == vb); exp_gt = (va > vb); exp_lt = (va < vb);
        exp_nd = 3'(m);
      end
      checks++;
      if (busy !== 1'(k <= m + 1)) begin
        failures++; $display("FAIL busy a=%h b=%h k=%0d got=%b exp=%b", ia, ib, k, busy, k <= m + 1);
      end
      checks++;
      if (done !== 1'(k == m + 1)) begin
        failures++; $display("FAIL done a=%h b=%h k=%0d got=%b exp=%b", ia, ib, k, done, k == m + 1);
      end
      checks++;
      if ({aeqb, agtb, altb, ndig} !== {exp_eq, exp_gt, exp_lt, exp_nd}) begin
        failures++;
        $display("FAIL result a=%h b=%h s=%b k=%0d got eq/gt/lt=%b%b%b nd=%0d exp=%b%b%b nd=%0d",
                 ia, ib, sm, k, aeqb, agtb, altb, ndig, exp_eq, exp_gt, exp_lt, exp_nd);
      end
    end
  endtask

  task automatic run8(input int sel, input logic [7:0] ia, input logic [7:0] ib,
                      input logic sm, output int dcyc);
    int m, w_d, va, vb;
    logic o_busy, o_done, o_eq, o_gt, o_lt;
    int o_nd;
    w_d = (sel == 0) ? 1 : 8;
    m  = first_diff(ia, ib, 8, w_d);
    va = value_of(ia, 8, sm);
    vb = value_of(ib, 8, sm);
    dcyc = -1;
    @(negedge clk);
    a8 = ia; b8 = ib; sm8 = sm;
    if (sel == 0) st1 = 1'b1; else st8 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0; st8 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        o_busy = busy1; o_done = done1; o_eq = eq1; o_gt = gt1; o_lt = lt1; o_nd = int'(nd1);
      end else begin
        o_busy = busy8; o_done = done8; o_eq = eq8; o_gt = gt8; o_lt = lt8; o_nd = int'(nd8);
      end
      if (o_done === 1'b1 && dcyc < 0) begin
        dcyc = k;
        checks++;
        if ({o_eq, o_gt, o_lt} !== {1'(va == vb), 1'(va > vb), 1'(va < vb)} || o_nd != m) begin
          failures++;
          $display("FAIL result8 sel=%0d a=%h b=%h s=%b got=%b%b%b nd=%0d exp=%b%b%b nd=%0d",
                   sel, ia, ib, sm, o_eq, o_gt, o_lt, o_nd, va == vb, va > vb, va < vb, m);
        end
      end
      if (dcyc > 0 && k == dcyc + 1) begin
        checks++;
        if (o_busy !== 1'b0) begin
          failures++; $display("FAIL busy8_after sel=%0d got=%b exp=0", sel, o_busy);
        end
        break;
      end
    end
    checks++;
    if (dcyc != m + 1) begin
      failures++; $display("FAIL done8_cycle sel=%0d a=%h b=%h got=%0d exp=%0d", sel, ia, ib, dcyc, m + 1);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, aeqb, agtb, altb, ndig} !== 8'd0 ||
        {busy1, done1, eq1, gt1, lt1, nd1, busy8, done8, eq8, gt8, lt8, nd8} !== 15'd0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {busy, done, aeqb, agtb, altb, ndig});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, aeqb, agtb, altb, ndig} !== 8'd0) begin
      failures++; $display("FAIL post_reset_idle got=%b exp=0", {busy, done, aeqb, agtb, altb, ndig});
    end
  endtask

  task automatic test_equal;
    int d;
    run16(16'h1234, 16'h1234, 1'b0, 1'b0, d);
    checks++;
    if (d != 5 || {aeqb, agtb, altb, ndig} !== {3'b100, 3'd4}) begin
      failures++; $display("FAIL equal_1234 done_cyc=%0d res=%b%b%b nd=%0d exp=5 100 4", d, aeqb, agtb, altb, ndig);
    end
  endtask

  task automatic test_early;
    int d;
    run16(16'h9000, 16'h8FFF, 1'b0, 1'b0, d);
    checks++;
    if (d != 2 || agtb !== 1'b1 || ndig !== 3'd1) begin
      failures++; $display("FAIL early_9000 done_cyc=%0d gt=%b nd=%0d exp=2 1 1", d, agtb, ndig);
    end
    run16(16'h12F0, 16'h12F1, 1'b0, 1'b0, d);
    checks++;
    if (d != 5 || altb !== 1'b1 || ndig !== 3'd4) begin
      failures++; $display("FAIL late_12F0 done_cyc=%0d lt=%b nd=%0d exp=5 1 4", d, altb, ndig);
    end
  endtask

  task automatic test_signed;
    int d;
    run16(16'h8000, 16'h0001, 1'b1, 1'b0, d);
    checks++;
    if (altb !== 1'b1 || ndig !== 3'd1) begin
      failures++; $display("FAIL signed_8000 lt=%b nd=%0d exp=1 1", altb, ndig);
    end
    run16(16'h8000, 16'h0001, 1'b0, 1'b0, d);
    checks++;
    if (agtb !== 1'b1) begin
      failures++; $display("FAIL unsigned_8000 gt=%b exp=1", agtb);
    end
    run16(16'hFFFF, 16'hFFFE, 1'b1, 1'b0, d);
    checks++;
    if (agtb !== 1'b1 || ndig !== 3'd4) begin
      failures++; $display("FAIL signed_FFFF gt=%b nd=%0d exp=1 4", agtb, ndig);
    end
  endtask

  task automatic test_random;
    int d;
    logic [15:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (16'(1) << $urandom_range(0, 15));
        2: rb = ra + 16'($urandom_range(0, 3)) - 16'd1;
        default: rb = 16'($urandom);
      endcase
      run16(ra, rb, 1'($urandom), bit'(i % 2), d);
    end
  endtask

  task automatic test_back_to_back;
    int m, p, ndone, va, vb;
    logic [15:0] ra, rb;
    logic sm;
    ra = 16'($urandom);
    rb = ra ^ (16'(1) << $urandom_range(0, 15));
    sm = 1'($urandom);
    m  = first_diff(ra, rb, 16, 4);
    p  = m + 2;
    va = value_of(ra, 16, sm);
    vb = value_of(rb, 16, sm);
    ndone = 0;
    @(negedge clk);
    a = ra; b = rb; signed_mode = sm; start = 1'b1;
    for (int k = 1; k <= 3 * p; k++) begin
      @(negedge clk);
      if (k == 3 * p) start = 1'b0;
      if (done === 1'b1) ndone++;
      checks++;
      if (busy !== 1'((k % p) != 0) || done !== 1'((k % p) == m + 1)) begin
        failures++;
        $display("FAIL held_start k=%0d busy=%b done=%b exp busy=%b done=%b", k, busy, done,
                 (k % p) != 0, (k % p) == m + 1);
      end
    end
    checks++;
    if (ndone != 3) begin
      failures++; $display("FAIL held_start_count got=%0d exp=3", ndone);
    end
    exp_eq = (va == vb); exp_gt = (va > vb); exp_lt = (va < vb); exp_nd = 3'(m);
    checks++;
    if ({aeqb, agtb, altb, ndig} !== {exp_eq, exp_gt, exp_lt, exp_nd}) begin
      failures++; $display("FAIL held_start_result got=%b%b%b nd=%0d exp=%b%b%b nd=%0d",
                           aeqb, agtb, altb, ndig, exp_eq, exp_gt, exp_lt, exp_nd);
    end
  endtask

  task automatic test_reset_mid;
    int d;
    logic [15:0] ra;
    ra = 16'($urandom);
    @(negedge clk);
    a = ra; b = ra; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, aeqb, agtb, altb, ndig} !== 8'd0) begin
      failures++; $display("FAIL reset_mid got=%b exp=0", {busy, done, aeqb, agtb, altb, ndig});
    end
    exp_eq = 1'b0; exp_gt = 1'b0; exp_lt = 1'b0; exp_nd = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, aeqb, agtb, altb, ndig} !== 8'd0) begin
        failures++; $display("FAIL reset_no_done k=%0d got=%b exp=0", k, {busy, done, aeqb, agtb, altb, ndig});
      end
    end
    run16(ra, ra, 1'b0, 1'b0, d);
    checks++;
    if (d != 5 || aeqb !== 1'b1) begin
      failures++; $display("FAIL reset_recover done_cyc=%0d eq=%b exp=5 1", d, aeqb);
    end
  endtask

  task automatic test_params;
    int d;
    run8(0, 8'h01, 8'h00, 1'b0, d);
    checks++;
    if (d != 9 || gt1 !== 1'b1 || nd1 !== 4'd8) begin
      failures++; $display("FAIL w8d1_01 done_cyc=%0d gt=%b nd=%0d exp=9 1 8", d, gt1, nd1);
    end
    run8(1, 8'h7F, 8'h80, 1'b1, d);
    checks++;
    if (d != 2 || gt8 !== 1'b1 || nd8 !== 1'b1) begin
      failures++; $display("FAIL w8d8_7F done_cyc=%0d gt=%b nd=%0d exp=2 1 1", d, gt8, nd8);
    end
    for (int i = 0; i < 10; i++) begin
      run8(i % 2, 8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom), d);
    end
  endtask

  initial begin
    test_reset;
    test_equal;
    test_early;
    test_signed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_params;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
